// File: rtl/ex_muldiv_stage.sv
// Execute stage with forwarding, ALU, destination select, HI/LO and an iterative mult/div FSM.
// Define EX_FAST_MUL_EN to use a single-cycle combinational multiplier for MULT/MULTU.
module ex_muldiv_stage #(
  parameter int NB_REG  = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_EXOP = 5,
  parameter int RA_ADDR = 31
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_flush,
  input  logic [NB_EXOP-1:0] i_ex_op,
  input  logic               i_alu_src,
  input  logic               i_reg_dst,
  input  logic               i_jal_sel,
  input  logic               i_reg_write,
  input  logic [NB_REG-1:0]  i_rs_data,
  input  logic [NB_REG-1:0]  i_rt_data,
  input  logic [NB_REG-1:0]  i_imm,
  input  logic [4:0]         i_shamt,
  input  logic [NB_REG-1:0]  i_pc_plus8,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  input  logic [NB_REG-1:0]  i_fwd_mem,
  input  logic [NB_REG-1:0]  i_fwd_wb,
  input  logic [1:0]         i_forward_a,
  input  logic [1:0]         i_forward_b,
  output logic [NB_REG-1:0]  o_result,
  output logic [NB_REG-1:0]  o_store_data,
  output logic [NB_ADDR-1:0] o_write_addr,
  output logic               o_reg_write,
  output logic               o_stall,
  output logic [NB_REG-1:0]  o_hi,
  output logic [NB_REG-1:0]  o_lo
);

  localparam int NB_CNT = $clog2(NB_REG + 1);
  localparam logic [NB_REG-1:0] ZERO    = {NB_REG{1'b0}};
  localparam logic [NB_REG-1:0] ONES    = {NB_REG{1'b1}};
  localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

  localparam logic [NB_EXOP-1:0] OP_ADD   = NB_EXOP'(5'd0);
  localparam logic [NB_EXOP-1:0] OP_SUB   = NB_EXOP'(5'd1);
  localparam logic [NB_EXOP-1:0] OP_AND   = NB_EXOP'(5'd2);
  localparam logic [NB_EXOP-1:0] OP_OR    = NB_EXOP'(5'd3);
  localparam logic [NB_EXOP-1:0] OP_XOR   = NB_EXOP'(5'd4);
  localparam logic [NB_EXOP-1:0] OP_NOR   = NB_EXOP'(5'd5);
  localparam logic [NB_EXOP-1:0] OP_SLT   = NB_EXOP'(5'd6);
  localparam logic [NB_EXOP-1:0] OP_SLTU  = NB_EXOP'(5'd7);
  localparam logic [NB_EXOP-1:0] OP_SLL   = NB_EXOP'(5'd8);
  localparam logic [NB_EXOP-1:0] OP_SRL   = NB_EXOP'(5'd9);
  localparam logic [NB_EXOP-1:0] OP_SRA   = NB_EXOP'(5'd10);
  localparam logic [NB_EXOP-1:0] OP_SLLV  = NB_EXOP'(5'd11);
  localparam logic [NB_EXOP-1:0] OP_SRLV  = NB_EXOP'(5'd12);
  localparam logic [NB_EXOP-1:0] OP_SRAV  = NB_EXOP'(5'd13);
  localparam logic [NB_EXOP-1:0] OP_LUI   = NB_EXOP'(5'd14);
  localparam logic [NB_EXOP-1:0] OP_MULT  = NB_EXOP'(5'd15);
  localparam logic [NB_EXOP-1:0] OP_MULTU = NB_EXOP'(5'd16);
  localparam logic [NB_EXOP-1:0] OP_DIV   = NB_EXOP'(5'd17);
  localparam logic [NB_EXOP-1:0] OP_DIVU  = NB_EXOP'(5'd18);
  localparam logic [NB_EXOP-1:0] OP_MFHI  = NB_EXOP'(5'd19);
  localparam logic [NB_EXOP-1:0] OP_MFLO  = NB_EXOP'(5'd20);
  localparam logic [NB_EXOP-1:0] OP_MTHI  = NB_EXOP'(5'd21);
  localparam logic [NB_EXOP-1:0] OP_MTLO  = NB_EXOP'(5'd22);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;

  state_t              state_r;
  logic [NB_CNT-1:0]   counter_r;
  logic [2*NB_REG-1:0] acc_r;
  logic [NB_REG-1:0]   op_r;
  logic                is_div_r, neg_res_r, neg_rem_r;
  logic [NB_REG-1:0]   hi_r, lo_r;

  logic [NB_REG-1:0]   a_s, b_fwd_s, b_alu_s, alu_s;
  logic                is_mul_s, is_div_s, signed_s, neg_a_s, neg_b_s, launch_s;
  logic [NB_REG-1:0]   mag_a_s, mag_b_s;
  logic [NB_REG:0]     div_shift_s, div_diff_s, mul_sum_s;
  logic [2*NB_REG-1:0] div_next_s, mul_next_s, prod_s;
  logic [NB_REG-1:0]   fin_hi_s, fin_lo_s;

  // Operand forwarding for A and B
  always_comb begin
    case (i_forward_a)
      2'b00:   a_s = i_rs_data;
      2'b01:   a_s = i_fwd_wb;
      2'b10:   a_s = i_fwd_mem;
      default: a_s = ZERO;
    endcase
    case (i_forward_b)
      2'b00:   b_fwd_s = i_rt_data;
      2'b01:   b_fwd_s = i_fwd_wb;
      2'b10:   b_fwd_s = i_fwd_mem;
      default: b_fwd_s = ZERO;
    endcase
    if (i_alu_src) b_alu_s = i_imm;
    else           b_alu_s = b_fwd_s;
  end

  // Single-cycle ALU, including HI/LO moves
  always_comb begin
    alu_s = ZERO;
    case (i_ex_op)
      OP_ADD:  alu_s = a_s + b_alu_s;
      OP_SUB:  alu_s = a_s - b_alu_s;
      OP_AND:  alu_s = a_s & b_alu_s;
      OP_OR:   alu_s = a_s | b_alu_s;
      OP_XOR:  alu_s = a_s ^ b_alu_s;
      OP_NOR:  alu_s = ~(a_s | b_alu_s);
      OP_SLT:  alu_s = {{(NB_REG-1){1'b0}}, ($signed(a_s) < $signed(b_alu_s))};
      OP_SLTU: alu_s = {{(NB_REG-1){1'b0}}, (a_s < b_alu_s)};
      OP_SLL:  alu_s = b_alu_s << i_shamt;
      OP_SRL:  alu_s = b_alu_s >> i_shamt;
      OP_SRA:  alu_s = $unsigned($signed(b_alu_s) >>> i_shamt);
      OP_SLLV: alu_s = b_alu_s << a_s[4:0];
      OP_SRLV: alu_s = b_alu_s >> a_s[4:0];
      OP_SRAV: alu_s = $unsigned($signed(b_alu_s) >>> a_s[4:0]);
      OP_LUI:  alu_s = b_alu_s << 5'd16;
      OP_MFHI: alu_s = hi_r;
      OP_MFLO: alu_s = lo_r;
      default: alu_s = ZERO;
    endcase
  end

  // Result and destination selection; the link path overrides both
  always_comb begin
    if (i_jal_sel) begin
      o_result     = i_pc_plus8;
      o_write_addr = NB_ADDR'(RA_ADDR);
    end else if (i_reg_dst) begin
      o_result     = alu_s;
      o_write_addr = i_rt_addr;
    end else begin
      o_result     = alu_s;
      o_write_addr = i_rd_addr;
    end
  end

  assign o_store_data = b_fwd_s;
  assign is_mul_s = (i_ex_op == OP_MULT) || (i_ex_op == OP_MULTU);
  assign is_div_s = (i_ex_op == OP_DIV) || (i_ex_op == OP_DIVU);
  assign signed_s = (i_ex_op == OP_MULT) || (i_ex_op == OP_DIV);
  assign neg_a_s  = signed_s & a_s[NB_REG-1];
  assign neg_b_s  = signed_s & b_fwd_s[NB_REG-1];
  assign mag_a_s  = neg_a_s ? -a_s : a_s;
  assign mag_b_s  = neg_b_s ? -b_fwd_s : b_fwd_s;
  // Flush beats launch, and drops the stall in the same cycle
  assign launch_s = (state_r == ST_IDLE) & i_valid & (is_mul_s | is_div_s) & ~i_flush;
  assign o_stall  = launch_s | ((state_r == ST_BUSY) & ~i_flush);
  assign o_reg_write = i_reg_write & i_valid & ~o_stall;

  // acc_r holds {remainder, quotient} for divide and {product hi, multiplier} for multiply
  assign div_shift_s = acc_r[2*NB_REG-1:NB_REG-1];
  assign div_diff_s  = div_shift_s - {1'b0, op_r};
  assign div_next_s  = div_diff_s[NB_REG] ? {div_shift_s[NB_REG-1:0], acc_r[NB_REG-2:0], 1'b0}
                                          : {div_diff_s[NB_REG-1:0], acc_r[NB_REG-2:0], 1'b1};
  assign mul_sum_s   = {1'b0, acc_r[2*NB_REG-1:NB_REG]} +
                       (acc_r[0] ? {1'b0, op_r} : {(NB_REG+1){1'b0}});
  assign mul_next_s  = {mul_sum_s, acc_r[NB_REG-1:1]};
  assign prod_s      = neg_res_r ? -acc_r : acc_r;

`ifdef EX_FAST_MUL_EN
  logic [2*NB_REG-1:0] fast_prod_s;
  assign fast_prod_s = {ZERO, mag_a_s} * {ZERO, mag_b_s};
`endif

  // Sign fix-up of the magnitude result, with the divide-by-zero override
  always_comb begin
    if (is_div_r) begin
      fin_hi_s = neg_rem_r ? -acc_r[2*NB_REG-1:NB_REG] : acc_r[2*NB_REG-1:NB_REG];
      if (op_r == ZERO) fin_lo_s = ONES;
      else              fin_lo_s = neg_res_r ? -acc_r[NB_REG-1:0] : acc_r[NB_REG-1:0];
    end else begin
      fin_hi_s = prod_s[2*NB_REG-1:NB_REG];
      fin_lo_s = prod_s[NB_REG-1:0];
    end
  end

  // Mult/div sequencer: capture magnitudes, iterate one bit per cycle, then retire
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      counter_r <= {NB_CNT{1'b0}};
      acc_r     <= {(2*NB_REG){1'b0}};
      op_r      <= ZERO;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else if (i_flush) begin
      state_r   <= ST_IDLE;
      counter_r <= {NB_CNT{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            is_div_r  <= is_div_s;
            neg_res_r <= neg_a_s ^ neg_b_s;
            neg_rem_r <= neg_a_s;
            counter_r <= NB_CNT'(NB_REG);
            if (is_div_s) begin
              acc_r   <= {ZERO, mag_a_s};
              op_r    <= mag_b_s;
              state_r <= ST_BUSY;
            end else begin
`ifdef EX_FAST_MUL_EN
              acc_r   <= fast_prod_s;
              op_r    <= mag_a_s;
              state_r <= ST_DONE;
`else
              acc_r   <= {ZERO, mag_b_s};
              op_r    <= mag_a_s;
              state_r <= ST_BUSY;
`endif
            end
          end
        end
        ST_BUSY: begin
          acc_r     <= is_div_r ? div_next_s : mul_next_s;
          counter_r <= counter_r - CNT_ONE;
          if (counter_r == CNT_ONE) state_r <= ST_DONE;
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // HI/LO update from mult/div completion or MTHI/MTLO
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hi_r <= ZERO;
      lo_r <= ZERO;
    end else if (!i_flush) begin
      if (state_r == ST_DONE) begin
        hi_r <= fin_hi_s;
        lo_r <= fin_lo_s;
      end else if (i_valid && !o_stall && (i_ex_op == OP_MTHI)) begin
        hi_r <= a_s;
      end else if (i_valid && !o_stall && (i_ex_op == OP_MTLO)) begin
        lo_r <= a_s;
      end
    end
  end

  assign o_hi = hi_r;
  assign o_lo = lo_r;

endmodule

// File: doc/ex_muldiv_stage.md
Name: ex_muldiv_stage

Overview:
Parametrised next-generation execute stage for the pipelined MIPS core. It keeps operand forwarding, the ALU, ALU-source selection and destination-register selection (rd/rt/$ra). It adds HI/LO registers and an iterative multiply/divide FSM that stalls the pipeline through a handshake with the hazard unit. It sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
NB_REG, 32, data/register width (>=8, even)
NB_ADDR, 5, register-address width
NB_EXOP, 5, width of decoded execute-operation code
RA_ADDR, 31, link register index used by JAL/JALR

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  instruction in EX is valid (not a bubble)
i_flush  in  1  abort in-flight mult/div, return FSM to IDLE
i_ex_op  in  NB_EXOP  decoded operation (encoding below)
i_alu_src  in  1  0: B = forwarded rt, 1: B = immediate
i_reg_dst  in  1  0: dest = rd, 1: dest = rt
i_jal_sel  in  1  1: dest = RA_ADDR, result = i_pc_plus8
i_reg_write  in  1  instruction writes GPR
i_rs_data  in  NB_REG  rs operand from ID
i_rt_data  in  NB_REG  rt operand from ID
i_imm  in  NB_REG  sign/zero-extended immediate
i_shamt  in  5  shift amount
i_pc_plus8  in  NB_REG  link value
i_rd_addr  in  NB_ADDR  rd index
i_rt_addr  in  NB_ADDR  rt index
i_fwd_mem  in  NB_REG  forwarded value from MEM
i_fwd_wb  in  NB_REG  forwarded value from WB
i_forward_a  in  2  00 rs, 01 WB, 10 MEM, 11 zero
i_forward_b  in  2  same encoding for rt
o_result  out  NB_REG  ALU / link / HI-LO move result
o_store_data  out  NB_REG  forwarded rt, for stores
o_write_addr  out  NB_ADDR  destination register index
o_reg_write  out  1  i_reg_write & i_valid & ~o_stall
o_stall  out  1  hold PC, IF/ID, ID/EX; bubble EX/MEM
o_hi  out  NB_REG  HI register
o_lo  out  NB_REG  LO register

Behaviour:
- Reset: HI = LO = 0, FSM = IDLE, counter = 0, o_stall = 0. Combinational outputs follow their inputs.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU
  - 8 SLL, 9 SRL, 10 SRA: shift B by i_shamt
  - 11 SLLV, 12 SRLV, 13 SRAV: shift B by A[4:0]
  - 14 LUI: B << 16
  - 15 MULT, 16 MULTU, 17 DIV, 18 DIVU
  - 19 MFHI, 20 MFLO, 21 MTHI, 22 MTLO
  - others: result 0
- ADD/SUB wrap modulo 2^NB_REG; no trap.
- ALU ops are single-cycle combinational. i_jal_sel overrides the result with i_pc_plus8.
- MTHI/MTLO write the forwarded A into HI/LO at the clock edge when i_valid and not stalled.
- Destination mux: rd or rt per i_reg_dst; RA_ADDR when i_jal_sel.
- FSM IDLE -> BUSY -> DONE -> IDLE:
  - Launch: IDLE with i_valid and a mult/div op. Capture operand magnitudes and sign flags, counter = NB_REG, o_stall = 1 in the launch cycle.
  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide), counter decrements, o_stall = 1. Go to DONE when counter reaches 1.
  - DONE: HI/LO written, o_stall = 0, held instruction retires without relaunch. Next state IDLE.
  - Total stall: NB_REG+1 cycles.
- Results:
  - Multiply: {HI,LO} = 2*NB_REG-bit product.
  - Divide: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV(U) by zero: LO = all ones, HI = dividend.
  - Signed most-negative / -1: LO = most-negative, HI = 0.
- i_flush in any state: FSM -> IDLE next edge, HI/LO unchanged, o_stall deasserts combinationally.
- Flush and launch in the same cycle: flush wins.
- MFHI/MFLO during BUSY stall naturally because o_stall is held.
- Reset mid-operation aborts immediately; HI/LO return to 0.

Optional Feature:
- EX_FAST_MUL_EN defined: MULT/MULTU use a combinational multiplier. Launch goes directly to DONE, so the stall is 1 cycle. Divide is unchanged.
- Not defined: multiply uses the iterative path (NB_REG+1 stall cycles).

Test Plan:
- ADD with rs=5, rt=7, forward_a=10, i_fwd_mem=100 -> o_result=107; o_write_addr=rd.
- JAL with i_pc_plus8=0x400 -> o_result=0x400, o_write_addr=31, o_reg_write=1.
- MULT 0xFFFFFFFE * 3 -> o_stall high 33 cycles (1 with EX_FAST_MUL_EN); then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU launched, i_flush at BUSY cycle 10 -> o_stall drops that cycle, HI/LO unchanged. Separately, i_rst_n low during BUSY -> HI=LO=0, o_stall=0.
